// File: rtl/pwm_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the three-phase dead-time insertion stage:
//   - phase_state_e : per-phase gate-drive FSM states (OFF, DT, HI, LO)
//   - N_PHASE_DEF   : default number of phases
//   - DT_W_DEF      : default width of the dead-time count
//   - MIN_DT        : smallest gap ever inserted, in clock cycles
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int N_PHASE_DEF = 3;
  localparam int DT_W_DEF    = 8;
  localparam int MIN_DT      = 1;

  typedef enum logic [1:0] {
    PH_OFF = 2'b00,
    PH_DT  = 2'b01,
    PH_HI  = 2'b10,
    PH_LO  = 2'b11
  } phase_state_e;

endpackage

// File: rtl/pwm_dt_phase.sv
// -----------------------------------------------------------------------------
// pwm_dt_phase
// One phase of the dead-time stage: turns a single high-side PWM reference into
// a non-overlapping high/low gate pair with a programmable both-off gap at
// every transition. Pulses shorter than the gap are swallowed because any
// input change during the gap retargets and restarts the count.
//
// Ports:
//   i_clk    clock
//   i_rst    asynchronous active-high reset
//   i_kill   force OFF on the next edge (enable low or fault)
//   i_pwm    high-side reference for this phase
//   i_dead   dead time in cycles (0 is treated as MIN_DT)
//   o_hi     registered high-side drive
//   o_lo     registered low-side drive
//   o_dt     registered "in dead-time gap" flag
//
// Outputs are registered from the next-state decode, so a reference change
// seen at an edge drops the old side at that same edge and the gate pair can
// never overlap: both drives come from one state register value.
// -----------------------------------------------------------------------------
module pwm_dt_phase
  import pwm_pkg::*;
#(
  parameter int DT_W = DT_W_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_kill,
  input  logic            i_pwm,
  input  logic [DT_W-1:0] i_dead,
  output logic            o_hi,
  output logic            o_lo,
  output logic            o_dt
);

  phase_state_e    r_state;
  phase_state_e    w_state_nxt;
  logic            r_tgt;
  logic            w_tgt_nxt;
  logic [DT_W-1:0] r_cnt;
  logic [DT_W-1:0] w_cnt_nxt;
  logic [DT_W-1:0] w_dead_ld;
  logic            r_hi;
  logic            r_lo;
  logic            r_dt;

  // Clamp the programmed gap to the minimum so the counter never starts at 0.
  function automatic logic [DT_W-1:0] dead_load(input logic [DT_W-1:0] dead);
    logic [DT_W-1:0] v;
    if (dead < DT_W'(MIN_DT)) begin
      v = DT_W'(MIN_DT);
    end else begin
      v = dead;
    end
    return v;
  endfunction

  assign w_dead_ld = dead_load(i_dead);

  // Next-state, target and counter decode for the phase FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt;
    w_cnt_nxt   = r_cnt;
    if (i_kill) begin
      w_state_nxt = PH_OFF;
      w_cnt_nxt   = {DT_W{1'b0}};
    end else begin
      case (r_state)
        PH_OFF: begin
          w_state_nxt = PH_DT;
          w_tgt_nxt   = i_pwm;
          w_cnt_nxt   = w_dead_ld;
        end
        PH_DT: begin
          if (i_pwm != r_tgt) begin
            // Input moved during the gap: follow it and restart the count.
            w_tgt_nxt = i_pwm;
            w_cnt_nxt = w_dead_ld;
          end else if (r_cnt <= DT_W'(MIN_DT)) begin
            w_state_nxt = r_tgt ? PH_HI : PH_LO;
            w_cnt_nxt   = {DT_W{1'b0}};
          end else begin
            w_cnt_nxt = r_cnt - DT_W'(1);
          end
        end
        PH_HI: begin
          if (i_pwm == 1'b0) begin
            w_state_nxt = PH_DT;
            w_tgt_nxt   = 1'b0;
            w_cnt_nxt   = w_dead_ld;
          end else begin
            w_state_nxt = PH_HI;
          end
        end
        PH_LO: begin
          if (i_pwm == 1'b1) begin
            w_state_nxt = PH_DT;
            w_tgt_nxt   = 1'b1;
            w_cnt_nxt   = w_dead_ld;
          end else begin
            w_state_nxt = PH_LO;
          end
        end
        default: begin
          w_state_nxt = PH_OFF;
          w_cnt_nxt   = {DT_W{1'b0}};
        end
      endcase
    end
  end

  // State, counter and registered gate outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= PH_OFF;
      r_tgt   <= 1'b0;
      r_cnt   <= {DT_W{1'b0}};
      r_hi    <= 1'b0;
      r_lo    <= 1'b0;
      r_dt    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cnt   <= w_cnt_nxt;
      r_hi    <= (w_state_nxt == PH_HI);
      r_lo    <= (w_state_nxt == PH_LO);
      r_dt    <= (w_state_nxt == PH_DT);
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;
  assign o_dt = r_dt;

endmodule

// File: rtl/pwm_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
// Three-phase dead-time insertion stage between the PWM generator and the
// gate-drive pads. Synchronises the pad enable (and, optionally, the pad
// fault), holds the fault latch and instantiates one pwm_dt_phase per phase.
//
// Ports:
//   wb_clk_i       sole clock (shared with the PWM generator)
//   wb_rst_i       asynchronous active-high reset
//   en_i           asynchronous enable from pad (2-flop synchronised)
//   pwm_i          per-phase high-side reference, synchronous to wb_clk_i
//   dead_cycles_i  dead time in cycles (quasi-static, 0 behaves as 1)
//   fault_i        asynchronous active-high fault from pad
//   fault_clr_i    fault clear request
//   hi_o / lo_o    registered per-phase gate drives
//   dt_active_o    registered per-phase "in dead-time gap" flag
//   fault_o        fault latched
//
// Build option: PWM_DT_FAULT_EN. When defined, the fault synchroniser, latch,
// fault_clr_i and fault_o are active. When undefined, fault_i/fault_clr_i are
// ignored, fault_o is 0 and the phases are only killed by enable.
// -----------------------------------------------------------------------------
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DT_W    = DT_W_DEF,
  parameter int N_PHASE = N_PHASE_DEF
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               en_i,
  input  logic [N_PHASE-1:0] pwm_i,
  input  logic [DT_W-1:0]    dead_cycles_i,
  input  logic               fault_i,
  input  logic               fault_clr_i,
  output logic [N_PHASE-1:0] hi_o,
  output logic [N_PHASE-1:0] lo_o,
  output logic [N_PHASE-1:0] dt_active_o,
  output logic               fault_o
);

  logic r_en_meta;
  logic r_en_sync;
  logic w_fault_term;
  logic w_kill;

  // Two-flop synchroniser for the pad enable.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_en_meta <= 1'b0;
      r_en_sync <= 1'b0;
    end else begin
      r_en_meta <= en_i;
      r_en_sync <= r_en_meta;
    end
  end

`ifdef PWM_DT_FAULT_EN
  logic r_flt_meta;
  logic r_flt_sync;
  logic r_fault;

  // Fault synchroniser and latch; a fresh fault wins over a clear request,
  // and clearing also needs the enable low so drives cannot restart at once.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_flt_meta <= 1'b0;
      r_flt_sync <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_flt_meta <= fault_i;
      r_flt_sync <= r_flt_meta;
      r_fault    <= r_flt_sync |
                    (r_fault & ~(fault_clr_i & ~r_en_sync & ~r_flt_sync));
    end
  end

  // The synchronised fault kills the phases in the same cycle the latch sets.
  assign w_fault_term = r_flt_sync | r_fault;
  assign fault_o      = r_fault;
`else
  logic w_unused_fault;

  assign w_unused_fault = fault_i | fault_clr_i;
  assign w_fault_term   = 1'b0;
  assign fault_o        = 1'b0;
`endif

  assign w_kill = ~r_en_sync | w_fault_term;

  for (genvar g = 0; g < N_PHASE; g++) begin : g_phase
    pwm_dt_phase #(
      .DT_W (DT_W)
    ) u_phase (
      .i_clk  (wb_clk_i),
      .i_rst  (wb_rst_i),
      .i_kill (w_kill),
      .i_pwm  (pwm_i[g]),
      .i_dead (dead_cycles_i),
      .o_hi   (hi_o[g]),
      .o_lo   (lo_o[g]),
      .o_dt   (dt_active_o[g])
    );
  end

endmodule

// File: tb/tb_pwm_deadtime.sv
// -----------------------------------------------------------------------------
// tb_pwm_deadtime
// Self-checking bench for pwm_deadtime. The reference model describes each
// phase by the edge at which its current gap started, the gap length and the
// target side: the phase is in its gap for D edges from that start, then
// drives the target side. Enable/fault reach the model two edges late.
// -----------------------------------------------------------------------------
module tb_pwm_deadtime;

  logic       clk;
  logic       rst;
  logic       en;
  logic [2:0] pwm;
  logic [7:0] dc;
  logic       fin;
  logic       fclr;
  logic [2:0] hi;
  logic [2:0] lo;
  logic [2:0] dta;
  logic       fo;

  int n_tests;
  int n_fail;
  int cyc;

  bit m_run [3];
  bit m_tgt [3];
  int m_s   [3];
  int m_d   [3];
  bit m_en1, m_en2, m_f1, m_f2, m_latch;
  logic [2:0] e_hi, e_lo, e_dt;
  logic       e_f;

  pwm_deadtime dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .en_i          (en),
    .pwm_i         (pwm),
    .dead_cycles_i (dc),
    .fault_i       (fin),
    .fault_clr_i   (fclr),
    .hi_o          (hi),
    .lo_o          (lo),
    .dt_active_o   (dta),
    .fault_o       (fo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int p = 0; p < 3; p++) begin
      m_run[p] = 1'b0;
      m_tgt[p] = 1'b0;
      m_s[p]   = 0;
      m_d[p]   = 1;
    end
    m_en1 = 1'b0; m_en2 = 1'b0; m_f1 = 1'b0; m_f2 = 1'b0; m_latch = 1'b0;
    e_hi = 3'b000; e_lo = 3'b000; e_dt = 3'b000; e_f = 1'b0;
  endtask

  task automatic model_edge();
    bit en_s, f_s, fterm, kill;
    int dd;
    en_s = m_en2; m_en2 = m_en1; m_en1 = en;
`ifdef PWM_DT_FAULT_EN
    f_s = m_f2; m_f2 = m_f1; m_f1 = fin;
    fterm   = f_s | m_latch;
    m_latch = f_s | (m_latch & !(fclr & !en_s & !f_s));
`else
    f_s = 1'b0;
    fterm = 1'b0;
    m_latch = f_s;
`endif
    e_f  = m_latch;
    kill = !en_s | fterm;
    dd   = (dc == 8'd0) ? 1 : int'(dc);
    for (int p = 0; p < 3; p++) begin
      if (kill) begin
        m_run[p] = 1'b0;
      end else if (!m_run[p] || (pwm[p] != m_tgt[p])) begin
        m_run[p] = 1'b1;
        m_tgt[p] = pwm[p];
        m_s[p]   = cyc;
        m_d[p]   = dd;
      end
      e_hi[p] = 1'b0; e_lo[p] = 1'b0; e_dt[p] = 1'b0;
      if (m_run[p]) begin
        if (cyc < m_s[p] + m_d[p]) e_dt[p] = 1'b1;
        else if (m_tgt[p])         e_hi[p] = 1'b1;
        else                       e_lo[p] = 1'b1;
      end
    end
  endtask

  // One clock: model follows the sampled inputs, outputs checked 1 unit later.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_reset();
    else     model_edge();
    #1;
    chk("hi_o", hi, e_hi);
    chk("lo_o", lo, e_lo);
    chk("dt_active_o", dta, e_dt);
    chk("fault_o", fo, e_f);
    chk("no_overlap", hi & lo, 3'b000);
  endtask

  initial begin
    int first_hi0, first_lo1, first_lo2, bl, dtc, hic;
    n_tests = 0; n_fail = 0; cyc = 0;
    model_reset();
    rst = 1'b1; en = 1'b1; pwm = 3'b001; dc = 8'd5; fin = 1'b0; fclr = 1'b0;

    // Reset held with enable high: everything stays low.
    for (int i = 0; i < 3; i++) step();
    rst = 1'b0;
    first_hi0 = -1; first_lo1 = -1; first_lo2 = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (first_hi0 < 0 && hi[0]) first_hi0 = i;
      if (first_lo1 < 0 && lo[1]) first_lo1 = i;
      if (first_lo2 < 0 && lo[2]) first_lo2 = i;
    end
    chk("en_to_hi0", first_hi0, 32'd8);
    chk("en_to_lo1", first_lo1, 32'd8);
    chk("en_to_lo2", first_lo2, 32'd8);

    // D = 5, phase 0 toggling every 40 cycles: exactly 5 gap cycles each time.
    for (int t = 0; t < 6; t++) begin
      pwm[0] = ~pwm[0];
      bl = 0; dtc = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (!hi[0] && !lo[0]) bl++;
        if (dta[0]) dtc++;
      end
      chk("gap5_both_low", bl, 32'd5);
      chk("gap5_dt_active", dtc, 32'd5);
    end

    // D = 8, 3-cycle pulse on phase 1 while low side on: swallowed.
    dc = 8'd8;
    for (int i = 0; i < 5; i++) step();
    bl = 0; hic = 0;
    for (int i = 0; i < 23; i++) begin
      pwm[1] = (i < 3) ? 1'b1 : 1'b0;
      step();
      if (!lo[1]) bl++;
      if (hi[1]) hic++;
    end
    chk("short_pulse_hi", hic, 32'd0);
    chk("short_pulse_lo_gap", bl, 32'd11);

    // D = 0 behaves as 1: random references every cycle.
    dc = 8'd0;
    for (int i = 0; i < 10000; i++) begin
      pwm = 3'($urandom);
      step();
    end

    // Fault path.
    pwm = 3'b010;
    dc  = 8'd3;
    for (int i = 0; i < 10; i++) step();
    fin = 1'b1;
    step(); step();
    fin = 1'b0;
    step();
`ifdef PWM_DT_FAULT_EN
    chk("fault_at_3", fo, 1'b1);
    chk("fault_outs_off", {hi, lo}, 6'd0);
    fclr = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("clr_with_en", fo, 1'b1);
    fclr = 1'b0; en = 1'b0;
    for (int i = 0; i < 3; i++) step();
    fclr = 1'b1;
    step();
    chk("clr_without_en", fo, 1'b0);
    fclr = 1'b0; en = 1'b1;
`else
    chk("fault_disabled", fo, 1'b0);
`endif
    for (int i = 0; i < 12; i++) step();

    // Random mix: references, dead time, enable, fault and clear.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 3; p++) if ($urandom_range(0, 5) == 0) pwm[p] = ~pwm[p];
      if ($urandom_range(0, 60) == 0)  dc = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 150) == 0) en = ~en;
      fin  = ($urandom_range(0, 400) == 0);
      fclr = ($urandom_range(0, 10) == 0);
      step();
    end
    fin = 1'b0; en = 1'b0; fclr = 1'b1;
    for (int i = 0; i < 4; i++) step();
    fclr = 1'b0; en = 1'b1; dc = 8'd2; pwm = 3'b000;
    for (int i = 0; i < 12; i++) step();

    // Maximum dead time: 255-cycle gap, counter does not wrap.
    dc = 8'd255;
    pwm[0] = 1'b1;
    bl = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (!hi[0] && !lo[0]) bl++;
    end
    chk("gap255_both_low", bl, 32'd255);
    chk("gap255_hi_after", hi[0], 1'b1);

    // Asynchronous reset while phase 0 drives its high side.
    dc = 8'd3;
    for (int i = 0; i < 5; i++) step();
    chk("pre_rst_hi0", hi[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("async_rst_hi", hi, 3'b000);
    chk("async_rst_lo", lo, 3'b000);
    step(); step();
    rst = 1'b0;
    first_hi0 = -1;
    for (int i = 1; i <= 15; i++) begin
      step();
      if (first_hi0 < 0 && hi[0]) first_hi0 = i;
    end
    chk("restart_hi0", first_hi0, 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
